// File: rtl/mux_3.sv
// Registered 3-to-1 word selector: one-cycle latency, illegal select (2'b11) holds the output.
// Optional sticky illegal-select flag sel_err is built when MUX_3_SEL_ERR_EN is defined.
module mux_3 #(
   parameter int WIDTH = 28
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] mux_out
`ifdef MUX_3_SEL_ERR_EN
   ,
   output logic             sel_err
`endif
);

   logic [WIDTH-1:0] mux_out_d;
   logic [WIDTH-1:0] mux_out_q;

   // The illegal code falls through to the default, which keeps the last good selection.
   always_comb begin
      mux_out_d = mux_out_q;
      case (sel)
         2'b00:   mux_out_d = in1;
         2'b01:   mux_out_d = in2;
         2'b10:   mux_out_d = in3;
         default: mux_out_d = mux_out_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mux_out_q <= '0;
      end else begin
         mux_out_q <= mux_out_d;
      end
   end

   assign mux_out = mux_out_q;

`ifdef MUX_3_SEL_ERR_EN
   logic sel_err_d;
   logic sel_err_q;

   // Once an illegal code is seen the flag stays set until the next reset.
   always_comb begin
      sel_err_d = sel_err_q | (sel == 2'b11);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_err_q <= 1'b0;
      end else begin
         sel_err_q <= sel_err_d;
      end
   end

   assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_3.sv
// Directed-vector bench for mux_3; expected values are hand-computed constants.
// Covers sel_err as well when MUX_3_SEL_ERR_EN is defined.
module tb_mux_3;

   localparam int WIDTH = 28;

   logic             clk;
   logic             reset;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [WIDTH-1:0] in3;
   logic [1:0]       sel;
   logic [WIDTH-1:0] mux_out;
`ifdef MUX_3_SEL_ERR_EN
   logic             sel_err;
`endif

   int totalChecks = 0;
   int badChecks   = 0;

   mux_3 #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .in1     (in1),
      .in2     (in2),
      .in3     (in3),
      .sel     (sel),
      .mux_out (mux_out)
`ifdef MUX_3_SEL_ERR_EN
      ,
      .sel_err (sel_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic checkErr(input string tag, input logic exp);
`ifdef MUX_3_SEL_ERR_EN
      checkOutput(tag, {{(WIDTH-1){1'b0}}, sel_err}, {{(WIDTH-1){1'b0}}, exp});
`endif
   endtask

   // Drive inputs, then sample just after the next rising edge.
   task automatic applyStimulus(input logic rst, input logic [1:0] s,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH-1:0] c);
      reset = rst;
      sel   = s;
      in1   = a;
      in2   = b;
      in3   = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      sel   = 2'b01;
      in1   = 28'h35;
      in2   = 28'h19F;
      in3   = 28'h111;

      applyStimulus(1'b1, 2'b01, 28'h35, 28'h19F, 28'h111);
      checkOutput("reset_edge1", mux_out, 28'h0);
      checkErr("reset_err1", 1'b0);
      applyStimulus(1'b1, 2'b01, 28'h35, 28'h19F, 28'h111);
      checkOutput("reset_edge2", mux_out, 28'h0);
      checkErr("reset_err2", 1'b0);

      applyStimulus(1'b0, 2'b01, 28'h35, 28'h19F, 28'h111);
      checkOutput("sel01", mux_out, 28'h19F);
      applyStimulus(1'b0, 2'b10, 28'h35, 28'h19F, 28'h111);
      checkOutput("sel10", mux_out, 28'h111);
      applyStimulus(1'b0, 2'b00, 28'h35, 28'h19F, 28'h111);
      checkOutput("sel00", mux_out, 28'h35);
      checkErr("no_err_legal", 1'b0);

      // Full-width passthrough, toggling every cycle with no bubbles.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 2'b10, 28'h8000001, 28'h19F, 28'hFFFFFFF);
         checkOutput("wide_in3", mux_out, 28'hFFFFFFF);
         applyStimulus(1'b0, 2'b00, 28'h8000001, 28'h19F, 28'hFFFFFFF);
         checkOutput("wide_in1", mux_out, 28'h8000001);
      end

      // Illegal select holds the previous output while data changes.
      applyStimulus(1'b0, 2'b00, 28'h35, 28'h19F, 28'h111);
      checkOutput("pre_illegal", mux_out, 28'h35);
      applyStimulus(1'b0, 2'b11, 28'h1, 28'h2, 28'h3);
      checkOutput("illegal1", mux_out, 28'h35);
      checkErr("err_set1", 1'b1);
      applyStimulus(1'b0, 2'b11, 28'hABCDEF0, 28'h7654321, 28'hFFFFFFF);
      checkOutput("illegal2", mux_out, 28'h35);
      checkErr("err_set2", 1'b1);
      applyStimulus(1'b0, 2'b11, 28'h0, 28'h0, 28'h0);
      checkOutput("illegal3", mux_out, 28'h35);
      applyStimulus(1'b0, 2'b01, 28'h0, 28'h19F, 28'h0);
      checkOutput("post_illegal", mux_out, 28'h19F);
      checkErr("err_sticky", 1'b1);

      // Mid-stream reset discards the in-flight selection.
      applyStimulus(1'b0, 2'b10, 28'h35, 28'h19F, 28'h111);
      checkOutput("pre_reset", mux_out, 28'h111);
      applyStimulus(1'b1, 2'b10, 28'h35, 28'h19F, 28'h111);
      checkOutput("mid_reset", mux_out, 28'h0);
      checkErr("err_cleared", 1'b0);
      applyStimulus(1'b0, 2'b01, 28'h35, 28'h19F, 28'h111);
      checkOutput("post_reset", mux_out, 28'h19F);
      checkErr("err_stays_clear", 1'b0);

      // Input change between edges must not reach the output early.
      applyStimulus(1'b0, 2'b00, 28'h35, 28'h19F, 28'h111);
      checkOutput("lat_before", mux_out, 28'h35);
      #2 in1 = 28'h36;
      #2 checkOutput("lat_between", mux_out, 28'h35);
      @(posedge clk);
      #1;
      checkOutput("lat_after", mux_out, 28'h36);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/mux_3.md
# mux_3

Registered 3-to-1 word selector for the datapath. It picks one of three WIDTH-bit operands under a 2-bit select and presents the result on a flopped output one clock later. A clean registered boundary lets it sit between pipeline stages without adding combinational depth downstream.

## Interface
- WIDTH, 28: width of each data input and of the output.
- clk  input  1  rising-edge clock; all state updates on this edge.
- reset  input  1  synchronous, active-high reset.
- in1  input  WIDTH  operand selected when sel = 2'b00.
- in2  input  WIDTH  operand selected when sel = 2'b01.
- in3  input  WIDTH  operand selected when sel = 2'b10.
- sel  input  2  select code.
- mux_out  output  WIDTH  registered selected operand.
- sel_err  output  1  sticky illegal-select flag. Present only with MUX_3_SEL_ERR_EN.
- Port order: clk, reset, in1, in2, in3, sel, mux_out[, sel_err].

## Operation
- Select decode, sampled at each rising clk edge when reset = 0:
  - sel = 00 -> mux_out <= in1
  - sel = 01 -> mux_out <= in2
  - sel = 10 -> mux_out <= in3
  - sel = 11 -> illegal code; mux_out holds its previous value.
- No state machine; the only state is the mux_out register and the optional sel_err flop.
- Width rules:
  - The output is a bit-exact copy of the chosen input.
  - No extension, truncation or arithmetic.
  - Every bit of WIDTH passes through unchanged, including the MSB.
- Inputs are fully unconstrained. Any value, including X-free all-ones, is passed through.

## Timing
- Latency: 1 cycle. Inputs and sel present before edge N appear on mux_out after edge N and stay stable until edge N+1.
- No combinational path from any input to mux_out.
- Reset:
  - When reset = 1 at a rising edge, mux_out <= 0 and sel_err <= 0, regardless of sel or data.
  - Reset has priority over every other condition.
  - Reset asserted mid-stream discards the in-flight selection. The first post-reset output is the selection sampled on the first edge with reset = 0.
- Before the first reset edge, mux_out is undefined. Benches must apply reset for at least 1 cycle.
- sel may change every cycle. Back-to-back changes produce back-to-back output changes with no bubbles.
- Illegal sel = 11 for k cycles holds mux_out for k cycles. The next legal sel updates mux_out on the following edge.

## Configuration
- Macro: MUX_3_SEL_ERR_EN.
- Defined:
  - The sel_err output port exists.
  - It is set to 1 on the edge that samples sel = 11 with reset = 0.
  - It then stays 1 until reset, so it is sticky.
  - mux_out behaviour is unchanged.
- Not defined:
  - The sel_err port and its flop are absent.
  - The illegal code still holds mux_out.

## Test plan
- Reset: drive reset = 1 for 2 cycles with sel = 01, in2 = 28'h19F -> mux_out = 0 (and sel_err = 0) after each reset edge.
- Basic select, with in1 = 28'h35, in2 = 28'h19F, in3 = 28'h111:
  - sel = 01, then 10, then 00, one cycle each.
  - Required: mux_out = 28'h19F, 28'h111, 28'h35 on the respective following edges.
- Full-width passthrough: in3 = 28'hFFFFFFF, in1 = 28'h8000001, sel alternating 10/00 every cycle -> mux_out alternates 28'hFFFFFFF / 28'h8000001 with no missed cycle.
- Illegal select:
  - Set sel = 00 with in1 = 28'h35, then sel = 11 for 3 cycles while in1..in3 change.
  - Required: mux_out stays 28'h35.
  - With MUX_3_SEL_ERR_EN, sel_err = 1 from the first illegal edge onward.
- Reset mid-stream: sel = 10, in3 = 28'h111, assert reset for 1 cycle, then release with sel = 01, in2 = 28'h19F -> mux_out = 0 on the reset edge and 28'h19F on the next edge; sel_err cleared.
- Latency check: change in1 from 28'h35 to 28'h36 between edges with sel = 00 -> mux_out does not change before the next rising edge and equals 28'h36 after it.
